// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the MEM stage: word/register widths, opcodes,
// writeback select encoding and the data-cache access FSM states.
package cpu_types_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int REG_WIDTH  = 5;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [REG_WIDTH-1:0]  regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        LUI   = 6'h0F,
        LW    = 6'h23,
        SW    = 6'h2B,
        LL    = 6'h30,
        SC    = 6'h38,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [1:0] {
        WB_PORTO = 2'b00,
        WB_LOAD  = 2'b01,
        WB_LUI   = 2'b10,
        WB_PCP4  = 2'b11
    } wbsel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/response bus between the MEM stage (master) and the dcache (slave).
interface mem_stage_if #(
    parameter int WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/link_reg.sv
// Load-linked reservation {valid, addr}; set by LL, cleared by SC or a matching
// coherence invalidate. Only instantiated when ATOMIC_EN is defined.
module link_reg #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_set,
    input  logic [WORD_W-1:0] i_set_addr,
    input  logic              i_clr,
    input  logic              i_inv,
    input  logic [WORD_W-1:0] i_inv_addr,
    input  logic [WORD_W-1:0] i_chk_addr,
    output logic              o_ok
);
    logic              r_valid;
    logic [WORD_W-1:0] r_addr;
    logic              w_inv_hit;

    assign w_inv_hit = i_inv & (i_inv_addr == r_addr);
    // An invalidate landing in the same cycle as the SC check makes the SC fail.
    assign o_ok      = r_valid & (r_addr == i_chk_addr) & ~w_inv_hit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_addr  <= i_set_addr;
        end else if (i_clr | w_inv_hit) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues dcache loads/stores, stalls until dhit, holds the MEM/WB latch.
// Optional LL/SC link register is enabled with macro ATOMIC_EN.
//   state | meaning
//   IDLE  | no access outstanding; new request driven combinationally
//   BUSY  | request outstanding, waiting for dhit
//   DONE  | access complete, request dropped, waiting for pipe_en
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH,
    parameter int REG_W  = REG_WIDTH
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              pipe_en,
    input  logic [REG_W-1:0]  regDest_in,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic [WORD_W-1:0] dmemstore_in,
    input  logic              regWr_in,
    input  logic [1:0]        MemToReg_in,
    input  logic              halt_in,
    input  logic [WORD_W-1:0] portO_in,
    input  logic [WORD_W-1:0] luiValue_in,
    input  logic [WORD_W-1:0] pcp4_in,
    input  opcode_t           op_mem,
    mem_stage_if.master       dc,
    output logic              mem_stall,
    output logic              regWr_wb,
    output logic [REG_W-1:0]  regDest_wb,
    output logic [WORD_W-1:0] wdat_wb,
    output logic              halt_wb,
    input  logic              link_inv,
    input  logic [WORD_W-1:0] link_inv_addr
);
    mem_state_t        r_state;
    logic [WORD_W-1:0] r_load_q;
    logic              r_regWr_wb;
    logic [REG_W-1:0]  r_regDest_wb;
    logic [WORD_W-1:0] r_wdat_wb;
    logic              r_halt_wb;

    logic              w_is_sc;
    logic              w_sc_fail;
    logic              w_sc_ok;
    logic              w_wen;
    logic              w_access;
    logic              w_active;
    logic              w_hit;
    logic              w_latch;
    logic [WORD_W-1:0] w_wdat;

    assign w_is_sc = (op_mem == SC);

`ifdef ATOMIC_EN
    logic w_link_ok;

    link_reg #(.WORD_W(WORD_W)) u_link_reg (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_set      (w_hit & (op_mem == LL)),
        .i_set_addr (portO_in),
        .i_clr      (w_latch & w_is_sc),
        .i_inv      (link_inv),
        .i_inv_addr (link_inv_addr),
        .i_chk_addr (portO_in),
        .o_ok       (w_link_ok)
    );

    assign w_sc_fail = w_is_sc & ~w_link_ok;
    // Success means the store actually completed; a failed SC never leaves IDLE.
    assign w_sc_ok   = (r_state == DONE);
`else
    logic w_unused_link;

    assign w_unused_link = ^{link_inv, link_inv_addr};
    assign w_sc_fail     = 1'b0;
    assign w_sc_ok       = 1'b1;
`endif

    assign w_wen    = dWEN_in & ~w_sc_fail;
    assign w_access = dREN_in | w_wen;
    assign w_active = (r_state != DONE);
    assign w_hit    = dc.dhit & w_access & w_active;

    // Gated by nRST so a reset mid-access drops the request in the same cycle.
    assign dc.dmemREN   = nRST & dREN_in & w_active;
    assign dc.dmemWEN   = nRST & w_wen & w_active;
    assign dc.dmemaddr  = portO_in;
    assign dc.dmemstore = dmemstore_in;
    assign mem_stall    = nRST & w_access & w_active;

    assign w_latch = pipe_en & ~mem_stall;

    always_comb begin
        w_wdat = portO_in;
        case (wbsel_t'(MemToReg_in))
            WB_PORTO: w_wdat = portO_in;
            WB_LOAD:  w_wdat = r_load_q;
            WB_LUI:   w_wdat = luiValue_in;
            WB_PCP4:  w_wdat = pcp4_in;
            default:  w_wdat = portO_in;
        endcase
        if (w_is_sc) begin
            w_wdat = WORD_W'(w_sc_ok);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_load_q <= '0;
        end else begin
            if (w_hit) begin
                r_load_q <= dc.dmemload;
            end
            case (r_state)
                IDLE:    if (w_hit) r_state <= DONE;
                         else if (w_access) r_state <= BUSY;
                BUSY:    if (w_hit) r_state <= DONE;
                         else if (!w_access) r_state <= IDLE;
                DONE:    if (pipe_en) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_regWr_wb   <= 1'b0;
            r_regDest_wb <= '0;
            r_wdat_wb    <= '0;
            r_halt_wb    <= 1'b0;
        end else if (w_latch) begin
            // Once halted, nothing further may write the register file.
            r_regWr_wb   <= regWr_in & ~r_halt_wb;
            r_regDest_wb <= regDest_in;
            r_wdat_wb    <= w_wdat;
            r_halt_wb    <= r_halt_wb | halt_in;
        end
    end

    assign regWr_wb   = r_regWr_wb;
    assign regDest_wb = r_regDest_wb;
    assign wdat_wb    = r_wdat_wb;
    assign halt_wb    = r_halt_wb;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle writeback cases plus
// hand-written load/store/reset/halt/LL-SC sequences (ATOMIC_EN aware).
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        pipe_en;
    logic [4:0]  regDest_in;
    logic        dREN_in;
    logic        dWEN_in;
    logic [31:0] dmemstore_in;
    logic        regWr_in;
    logic [1:0]  MemToReg_in;
    logic        halt_in;
    logic [31:0] portO_in;
    logic [31:0] luiValue_in;
    logic [31:0] pcp4_in;
    opcode_t     op_mem;
    logic        mem_stall;
    logic        regWr_wb;
    logic [4:0]  regDest_wb;
    logic [31:0] wdat_wb;
    logic        halt_wb;
    logic        link_inv;
    logic [31:0] link_inv_addr;

    int checks   = 0;
    int failures = 0;

    mem_stage_if dc_if ();

    mem_stage dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pipe_en       (pipe_en),
        .regDest_in    (regDest_in),
        .dREN_in       (dREN_in),
        .dWEN_in       (dWEN_in),
        .dmemstore_in  (dmemstore_in),
        .regWr_in      (regWr_in),
        .MemToReg_in   (MemToReg_in),
        .halt_in       (halt_in),
        .portO_in      (portO_in),
        .luiValue_in   (luiValue_in),
        .pcp4_in       (pcp4_in),
        .op_mem        (op_mem),
        .dc            (dc_if),
        .mem_stall     (mem_stall),
        .regWr_wb      (regWr_wb),
        .regDest_wb    (regDest_wb),
        .wdat_wb       (wdat_wb),
        .halt_wb       (halt_wb),
        .link_inv      (link_inv),
        .link_inv_addr (link_inv_addr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  m2r;
        logic [31:0] porto;
        logic [31:0] lui;
        logic [31:0] pcp4;
        logic [4:0]  rd;
        logic        rw;
        logic        dhit;
        logic [31:0] dload;
        logic [31:0] exp_wdat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic nop();
        dREN_in         = 1'b0;
        dWEN_in         = 1'b0;
        regWr_in        = 1'b0;
        halt_in         = 1'b0;
        MemToReg_in     = 2'b00;
        op_mem          = RTYPE;
        dc_if.dhit      = 1'b0;
        link_inv        = 1'b0;
        link_inv_addr   = 32'h0;
    endtask

    // Load-linked style load at addr with immediate dhit, then retire it.
    task automatic load_now(input opcode_t op, input logic [31:0] addr, input logic [31:0] data);
        nop();
        dREN_in = 1'b1; op_mem = op; MemToReg_in = 2'b01; regWr_in = 1'b1;
        regDest_in = 5'd5; portO_in = addr;
        dc_if.dhit = 1'b1; dc_if.dmemload = data;
        tick();
        dc_if.dhit = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'h0000_0007, 32'h1111_0000, 32'h0000_0100, 5'd1,  1'b1, 1'b0, 32'h0,         32'h0000_0007};
        vecs[1] = '{2'b10, 32'h0000_0008, 32'hABCD_0000, 32'h0000_0200, 5'd2,  1'b1, 1'b0, 32'h0,         32'hABCD_0000};
        vecs[2] = '{2'b11, 32'h0000_0009, 32'h2222_0000, 32'h0000_0404, 5'd31, 1'b1, 1'b0, 32'h0,         32'h0000_0404};
        vecs[3] = '{2'b01, 32'h0000_000A, 32'h3333_0000, 32'h0000_0300, 5'd4,  1'b1, 1'b1, 32'h0000_0055, 32'hDEAD_BEEF};
        vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'h4444_0000, 32'h0000_0500, 5'd0,  1'b0, 1'b0, 32'h0,         32'hFFFF_FFFF};

        nRST = 1'b0; pipe_en = 1'b1; nop();
        regDest_in = '0; dmemstore_in = '0; portO_in = '0; luiValue_in = '0; pcp4_in = '0;
        dc_if.dmemload = '0;
        #1;
        chk("reset_wdat",  wdat_wb,  32'h0);
        chk("reset_regwr", {31'b0, regWr_wb}, 32'h0);
        chk("reset_halt",  {31'b0, halt_wb},  32'h0);
        chk("reset_stall", {31'b0, mem_stall}, 32'h0);
        tick(); tick();
        nRST = 1'b1;
        tick();

        // Load with dhit on the third stall cycle
        dREN_in = 1'b1; op_mem = LW; MemToReg_in = 2'b01; regWr_in = 1'b1;
        regDest_in = 5'd3; portO_in = 32'h40;
        #1;
        chk("lw_ren_c1",   {31'b0, dc_if.dmemREN}, 32'h1);
        chk("lw_addr",     dc_if.dmemaddr, 32'h40);
        chk("lw_stall_c1", {31'b0, mem_stall}, 32'h1);
        tick();
        chk("lw_stall_c2", {31'b0, mem_stall}, 32'h1);
        chk("lw_ren_c2",   {31'b0, dc_if.dmemREN}, 32'h1);
        tick();
        dc_if.dhit = 1'b1; dc_if.dmemload = 32'hDEAD_BEEF;
        #1;
        chk("lw_stall_c3", {31'b0, mem_stall}, 32'h1);
        tick();
        dc_if.dhit = 1'b0;
        #1;
        chk("lw_stall_done", {31'b0, mem_stall}, 32'h0);
        chk("lw_ren_done",   {31'b0, dc_if.dmemREN}, 32'h0);
        chk("lw_wdat_hold",  wdat_wb, 32'h0);
        tick();
        chk("lw_wdat",   wdat_wb, 32'hDEAD_BEEF);
        chk("lw_regwr",  {31'b0, regWr_wb}, 32'h1);
        chk("lw_regdst", {27'b0, regDest_wb}, 32'd3);
        nop();

        // Store with dhit in the first cycle
        dWEN_in = 1'b1; op_mem = SW; portO_in = 32'h80; dmemstore_in = 32'h1234; dc_if.dhit = 1'b1;
        #1;
        chk("sw_wen",   {31'b0, dc_if.dmemWEN}, 32'h1);
        chk("sw_ren",   {31'b0, dc_if.dmemREN}, 32'h0);
        chk("sw_data",  dc_if.dmemstore, 32'h1234);
        chk("sw_addr",  dc_if.dmemaddr, 32'h80);
        chk("sw_stall", {31'b0, mem_stall}, 32'h1);
        tick();
        dc_if.dhit = 1'b0;
        #1;
        chk("sw_wen_done",   {31'b0, dc_if.dmemWEN}, 32'h0);
        chk("sw_stall_done", {31'b0, mem_stall}, 32'h0);
        tick();
        chk("sw_regwr", {31'b0, regWr_wb}, 32'h0);
        nop();

        // Non-memory writeback select table
        for (int i = 0; i < 5; i++) begin
            MemToReg_in = vecs[i].m2r; portO_in = vecs[i].porto; luiValue_in = vecs[i].lui;
            pcp4_in = vecs[i].pcp4; regDest_in = vecs[i].rd; regWr_in = vecs[i].rw;
            dc_if.dhit = vecs[i].dhit; dc_if.dmemload = vecs[i].dload;
            #1;
            chk($sformatf("vec%0d_ren", i),   {31'b0, dc_if.dmemREN}, 32'h0);
            chk($sformatf("vec%0d_wen", i),   {31'b0, dc_if.dmemWEN}, 32'h0);
            chk($sformatf("vec%0d_stall", i), {31'b0, mem_stall}, 32'h0);
            tick();
            chk($sformatf("vec%0d_wdat", i),  wdat_wb, vecs[i].exp_wdat);
            chk($sformatf("vec%0d_regwr", i), {31'b0, regWr_wb}, {31'b0, vecs[i].rw});
            chk($sformatf("vec%0d_regdst", i), {27'b0, regDest_wb}, {27'b0, vecs[i].rd});
        end
        nop();

        // pipe_en low holds the MEM/WB latch
        pipe_en = 1'b0; portO_in = 32'h99; regWr_in = 1'b1;
        tick();
        chk("hold_wdat", wdat_wb, 32'hFFFF_FFFF);

        // DONE waits for pipe_en and ignores a further dhit
        nop();
        dREN_in = 1'b1; op_mem = LW; MemToReg_in = 2'b01; regWr_in = 1'b1; regDest_in = 5'd9;
        portO_in = 32'h44; dc_if.dhit = 1'b1; dc_if.dmemload = 32'h1234_5678;
        #1;
        chk("done_stall_c1", {31'b0, mem_stall}, 32'h1);
        tick();
        dc_if.dhit = 1'b1; dc_if.dmemload = 32'h0000_0BAD;
        #1;
        chk("done_stall", {31'b0, mem_stall}, 32'h0);
        chk("done_ren",   {31'b0, dc_if.dmemREN}, 32'h0);
        tick();
        dc_if.dhit = 1'b0;
        chk("done_wait_wdat", wdat_wb, 32'hFFFF_FFFF);
        chk("done_wait_ren",  {31'b0, dc_if.dmemREN}, 32'h0);
        pipe_en = 1'b1;
        tick();
        chk("done_wdat", wdat_wb, 32'h1234_5678);
        nop();

`ifdef ATOMIC_EN
        load_now(LL, 32'h100, 32'h77);
        chk("ll_wdat", wdat_wb, 32'h77);
        nop();
        dWEN_in = 1'b1; op_mem = SC; regWr_in = 1'b1; regDest_in = 5'd6; portO_in = 32'h100;
        dmemstore_in = 32'hAA;
        #1;
        chk("sc_ok_wen", {31'b0, dc_if.dmemWEN}, 32'h1);
        dc_if.dhit = 1'b1;
        tick();
        dc_if.dhit = 1'b0;
        tick();
        chk("sc_ok_wdat", wdat_wb, 32'h1);
        load_now(LL, 32'h100, 32'h78);
        nop();
        link_inv = 1'b1; link_inv_addr = 32'h100;
        tick();
        nop();
        dWEN_in = 1'b1; op_mem = SC; regWr_in = 1'b1; regDest_in = 5'd6; portO_in = 32'h100;
        #1;
        chk("sc_fail_wen",   {31'b0, dc_if.dmemWEN}, 32'h0);
        chk("sc_fail_stall", {31'b0, mem_stall}, 32'h0);
        tick();
        chk("sc_fail_wdat", wdat_wb, 32'h0);
        nop();
`else
        load_now(LL, 32'h100, 32'h77);
        chk("ll_wdat", wdat_wb, 32'h77);
        nop();
        dWEN_in = 1'b1; op_mem = SC; regWr_in = 1'b1; regDest_in = 5'd6; portO_in = 32'h100;
        #1;
        chk("sc_wen", {31'b0, dc_if.dmemWEN}, 32'h1);
        dc_if.dhit = 1'b1;
        tick();
        dc_if.dhit = 1'b0;
        tick();
        chk("sc_wdat", wdat_wb, 32'h1);
        nop();
`endif

        // Reset while BUSY
        dREN_in = 1'b1; op_mem = LW; MemToReg_in = 2'b01; regWr_in = 1'b1; regDest_in = 5'd8;
        portO_in = 32'h200;
        #1;
        chk("rst_ren_pre", {31'b0, dc_if.dmemREN}, 32'h1);
        tick();
        chk("rst_busy_stall", {31'b0, mem_stall}, 32'h1);
        nRST = 1'b0;
        #1;
        chk("rst_ren",    {31'b0, dc_if.dmemREN}, 32'h0);
        chk("rst_wen",    {31'b0, dc_if.dmemWEN}, 32'h0);
        chk("rst_stall",  {31'b0, mem_stall}, 32'h0);
        chk("rst_wdat",   wdat_wb, 32'h0);
        chk("rst_regwr",  {31'b0, regWr_wb}, 32'h0);
        chk("rst_regdst", {27'b0, regDest_wb}, 32'h0);
        nop();
        tick();
        nRST = 1'b1;
        dREN_in = 1'b1; op_mem = LW; MemToReg_in = 2'b01; regWr_in = 1'b1; regDest_in = 5'd8;
        portO_in = 32'h300; dc_if.dhit = 1'b1; dc_if.dmemload = 32'hCAFE_F00D;
        #1;
        chk("post_rst_ren", {31'b0, dc_if.dmemREN}, 32'h1);
        tick();
        dc_if.dhit = 1'b0;
        tick();
        chk("post_rst_wdat", wdat_wb, 32'hCAFE_F00D);
        nop();

        // Halt is sticky and blocks later register writes
        halt_in = 1'b1; regWr_in = 1'b1; portO_in = 32'h5; regDest_in = 5'd7; op_mem = HALT;
        tick();
        chk("halt_set",   {31'b0, halt_wb}, 32'h1);
        chk("halt_regwr", {31'b0, regWr_wb}, 32'h1);
        halt_in = 1'b0; op_mem = RTYPE;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("halt_stay%0d", i),  {31'b0, halt_wb}, 32'h1);
            chk($sformatf("halt_nowr%0d", i), {31'b0, regWr_wb}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
